sequence_bcd_generator: RTL and testbench

Parametrised integer-sequence generator with a built-in serial binary-to-BCD converter, the successor to the fixed Fibonacci counter + number display pairing. It produces Fibonacci, Lucas or counting sequences of any width. Each term is converted to packed BCD by a multi-cycle double-dabble engine, and a top level feeds the BCD digits to glyph rendering. It adds run/step/clear control, overflow detection with halt or wrap policy, and a conversion-done strobe.

---
 rtl/sequence_bcd_generator_if.sv | 26 ++
 rtl/sequence_bcd_generator.sv | 144 ++++++++++++++
 tb/tb_sequence_bcd_generator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_bcd_generator_if.sv
// Control and result bundle for sequence_bcd_generator.
// DIGITS is ceil(NUMBER_WIDTH*log10(2)), derived in fixed point.
interface sequence_bcd_generator_if #(
  parameter int NUMBER_WIDTH = 16
);
  localparam int DIGITS = (NUMBER_WIDTH * 30103 + 99999) / 100000;

  logic                    run;
  logic                    step;
  logic                    clear;
  logic [NUMBER_WIDTH-1:0] value;
  logic [4*DIGITS-1:0]     bcd;
  logic                    bcd_valid;
  logic                    busy;
  logic                    overflow;

  modport master (
    output run, step, clear,
    input  value, bcd, bcd_valid, busy, overflow
  );

  modport slave (
    input  run, step, clear,
    output value, bcd, bcd_valid, busy, overflow
  );
endinterface

// File: rtl/sequence_bcd_generator.sv
// Fibonacci / counter / Lucas term generator with a serial double-dabble
// binary-to-BCD converter (one bit per cycle).
module sequence_bcd_generator #(
  parameter int NUMBER_WIDTH = 16,
  parameter int MODE         = 0,
  parameter int WRAP         = 0
) (
  input logic                    clk,
  input logic                    rst,
  sequence_bcd_generator_if.slave bus
);
  localparam int DIGITS = (NUMBER_WIDTH * 30103 + 99999) / 100000;
  localparam int BW     = 4 * DIGITS;
  localparam int KW     = $clog2(NUMBER_WIDTH + 1);

  localparam logic [1:0] CONV = 2'd0;
  localparam logic [1:0] DONE = 2'd1;
  localparam logic [1:0] ADV  = 2'd2;

  localparam logic [NUMBER_WIDTH-1:0] SEED_A = NUMBER_WIDTH'((MODE == 2) ? 2 : 0);
  localparam logic [NUMBER_WIDTH:0]   SEED_B = (NUMBER_WIDTH + 1)'((MODE == 1) ? 0 : 1);

  logic [1:0]              state;
  logic [KW-1:0]           k;
  logic [NUMBER_WIDTH-1:0] a;
  logic [NUMBER_WIDTH:0]   b;
  logic [NUMBER_WIDTH-1:0] bin_work;
  logic [BW-1:0]           bcd_work;
  logic [BW-1:0]           shifted;
  logic [NUMBER_WIDTH-1:0] value_q;
  logic [BW-1:0]           bcd_q;
  logic                    bcd_valid_q;
  logic                    overflow_q;
  logic                    halted;
  logic                    step_pending;
  logic                    go;
  logic                    adv_overflow;
  logic [NUMBER_WIDTH-1:0] next_a;
  logic [NUMBER_WIDTH:0]   b_sum;

  // Add-3 and shift fused per nibble; each nibble's old MSB carries into the
  // next nibble's LSB, and the top carry is always zero for the derived DIGITS.
  always_comb begin : dabble
    logic [3:0] nib;
    logic       carry;
    shifted = '0;
    carry   = bin_work[NUMBER_WIDTH-1];
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib = bcd_work[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      shifted[4*i +: 4] = {nib[2:0], carry};
      carry = nib[3];
    end
  end

  always_comb begin
    b_sum        = {1'b0, a} + b;
    adv_overflow = (MODE == 1) ? (&a) : b[NUMBER_WIDTH];
    next_a       = (MODE == 1) ? (a + 1'b1) : b[NUMBER_WIDTH-1:0];
    go           = (bus.run | step_pending | bus.step) & ~halted;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= CONV;
      k            <= '0;
      a            <= SEED_A;
      b            <= SEED_B;
      bin_work     <= SEED_A;
      bcd_work     <= '0;
      value_q      <= '0;
      bcd_q        <= '0;
      bcd_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      halted       <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      bcd_valid_q  <= 1'b0;
      step_pending <= (step_pending | bus.step) & ~halted;
      if (bus.clear) begin
        state        <= CONV;
        k            <= '0;
        a            <= SEED_A;
        b            <= SEED_B;
        bin_work     <= SEED_A;
        bcd_work     <= '0;
        overflow_q   <= 1'b0;
        halted       <= 1'b0;
        step_pending <= 1'b0;
      end else begin
        case (state)
          CONV: begin
            bin_work <= bin_work << 1;
            bcd_work <= shifted;
            k        <= k + 1'b1;
            if (k == KW'(NUMBER_WIDTH - 1)) begin
              bcd_q       <= shifted;
              value_q     <= a;
              bcd_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
          DONE: begin
            if (go) begin
              state        <= ADV;
              step_pending <= 1'b0;
            end
          end
          ADV: begin
            if (!adv_overflow) begin
              a        <= next_a;
              if (MODE != 1) b <= b_sum;
              bin_work <= next_a;
              bcd_work <= '0;
              k        <= '0;
              state    <= CONV;
            end else if (WRAP != 0) begin
              a          <= SEED_A;
              b          <= SEED_B;
              bin_work   <= SEED_A;
              bcd_work   <= '0;
              k          <= '0;
              overflow_q <= 1'b1;
              state      <= CONV;
            end else begin
              overflow_q <= 1'b1;
              halted     <= 1'b1;
              state      <= DONE;
            end
          end
          default: begin
            state <= DONE;
          end
        endcase
      end
    end
  end

  assign bus.value     = value_q;
  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = (state != DONE);
endmodule

// File: tb/tb_sequence_bcd_generator.sv
// Scoreboard bench for sequence_bcd_generator: four configurations run side
// by side, each strobe popped against a queue of bench-computed terms.
module tb_sequence_bcd_generator;
  typedef struct {
    longint unsigned val;
    logic            ovf;
  } exp_t;

  logic clk;
  logic rst_a, rst_b, rst_c, rst_d;

  int vectors    = 0;
  int miscompares = 0;

  exp_t  q [4][$];
  bit    strict [4];
  string tags [4] = '{"A_fib8", "B_cnt8", "C_luc8", "D_fib16"};

  sequence_bcd_generator_if #(.NUMBER_WIDTH(8))  ia ();
  sequence_bcd_generator_if #(.NUMBER_WIDTH(8))  ib ();
  sequence_bcd_generator_if #(.NUMBER_WIDTH(8))  ic ();
  sequence_bcd_generator_if #(.NUMBER_WIDTH(16)) id ();

  sequence_bcd_generator #(.NUMBER_WIDTH(8),  .MODE(0), .WRAP(0)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
  sequence_bcd_generator #(.NUMBER_WIDTH(8),  .MODE(1), .WRAP(1)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));
  sequence_bcd_generator #(.NUMBER_WIDTH(8),  .MODE(2), .WRAP(0)) dut_c (.clk(clk), .rst(rst_c), .bus(ic));
  sequence_bcd_generator #(.NUMBER_WIDTH(16), .MODE(0), .WRAP(0)) dut_d (.clk(clk), .rst(rst_d), .bus(id));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] to_bcd(input longint unsigned v);
    logic [63:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < 16; i++) begin
      r = r | (64'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input longint unsigned v, input logic o);
    exp_t e;
    e.val = v;
    e.ovf = o;
    q[d].push_back(e);
  endtask

  task automatic wait_empty(input int d, input int budget, input string tag);
    int n;
    n = 0;
    while (q[d].size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 64'(q[d].size()), 64'd0);
  endtask

  task automatic pulse_step_a();
    @(negedge clk); ia.step = 1'b1;
    @(negedge clk); ia.step = 1'b0;
  endtask

  // Scoreboard consumer: every strobe pops one expected term.
  logic        mv [4];
  logic [63:0] mval [4];
  logic [63:0] mbcd [4];
  logic        movf [4];
  exp_t        me;

  always @(negedge clk) begin
    mv   = '{ia.bcd_valid, ib.bcd_valid, ic.bcd_valid, id.bcd_valid};
    mval = '{64'(ia.value), 64'(ib.value), 64'(ic.value), 64'(id.value)};
    mbcd = '{64'(ia.bcd), 64'(ib.bcd), 64'(ic.bcd), 64'(id.bcd)};
    movf = '{ia.overflow, ib.overflow, ic.overflow, id.overflow};
    for (int d = 0; d < 4; d++) begin
      if (mv[d] === 1'b1) begin
        if (q[d].size() == 0) begin
          if (strict[d]) chk({tags[d], "_spurious_strobe"}, 64'(mv[d]), 64'd0);
        end else begin
          me = q[d].pop_front();
          chk({tags[d], "_value"}, mval[d], 64'(me.val));
          chk({tags[d], "_bcd"}, mbcd[d], to_bcd(me.val));
          chk({tags[d], "_overflow"}, 64'(movf[d]), 64'(me.ovf));
        end
      end
    end
  end

  initial begin
    longint unsigned x, y, t;
    strict = '{1'b1, 1'b1, 1'b1, 1'b1};
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    ia.run = 1'b0; ia.step = 1'b0; ia.clear = 1'b0;
    ib.run = 1'b1; ib.step = 1'b0; ib.clear = 1'b0;
    ic.run = 1'b0; ic.step = 1'b0; ic.clear = 1'b0;
    id.run = 1'b1; id.step = 1'b0; id.clear = 1'b0;
    repeat (2) @(negedge clk);

    chk("A_rst_value", 64'(ia.value), 64'd0);
    chk("A_rst_bcd", 64'(ia.bcd), 64'd0);
    chk("A_rst_valid", 64'(ia.bcd_valid), 64'd0);
    chk("A_rst_overflow", 64'(ia.overflow), 64'd0);
    chk("A_rst_busy", 64'(ia.busy), 64'd1);
    chk("C_rst_value", 64'(ic.value), 64'd0);
    chk("D_rst_busy", 64'(id.busy), 64'd1);

    x = 0; y = 1;
    while (x < 256) begin push(0, x, 1'b0); t = x + y; x = y; y = t; end
    x = 0; y = 1;
    while (x < 65536) begin push(3, x, 1'b0); t = x + y; x = y; y = t; end
    for (int i = 0; i < 256; i++) push(1, longint'(i), 1'b0);
    for (int i = 0; i < 5; i++) push(1, longint'(i), 1'b1);
    push(2, 2, 1'b0);

    ia.run = 1'b1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;

    // First strobe on the 8th edge, then one every 10 edges.
    repeat (7) @(posedge clk);
    @(negedge clk); chk("A_first_strobe_early", 64'(ia.bcd_valid), 64'd0);
    @(posedge clk);
    @(negedge clk); chk("A_first_strobe", 64'(ia.bcd_valid), 64'd1);
    repeat (9) @(posedge clk);
    @(negedge clk); chk("A_period_gap", 64'(ia.bcd_valid), 64'd0);
    @(posedge clk);
    @(negedge clk); chk("A_period_strobe", 64'(ia.bcd_valid), 64'd1);

    wait_empty(0, 400, "A_fib_terms_timeout");
    repeat (5) @(negedge clk);
    pulse_step_a();
    repeat (30) @(negedge clk);
    chk("A_halt_overflow", 64'(ia.overflow), 64'd1);
    chk("A_halt_busy", 64'(ia.busy), 64'd0);
    chk("A_halt_value", 64'(ia.value), 64'd233);
    chk("A_halt_bcd", 64'(ia.bcd), 64'h233);

    // clear after halt, then clear again mid-conversion of 55
    x = 0; y = 1;
    while (x <= 34) begin push(0, x, 1'b0); t = x + y; x = y; y = t; end
    @(negedge clk); ia.clear = 1'b1;
    @(negedge clk); ia.clear = 1'b0;
    chk("A_clear_overflow", 64'(ia.overflow), 64'd0);
    wait_empty(0, 200, "A_restart_timeout");
    repeat (5) @(posedge clk);
    @(negedge clk); ia.clear = 1'b1; ia.run = 1'b0; push(0, 0, 1'b0);
    @(posedge clk);
    @(negedge clk); ia.clear = 1'b0;
    chk("A_midclr_bcd_hold", 64'(ia.bcd), 64'h034);
    chk("A_midclr_busy", 64'(ia.busy), 64'd1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("A_midclr_early", 64'(ia.bcd_valid), 64'd0);
    chk("A_midclr_bcd_still", 64'(ia.bcd), 64'h034);
    @(posedge clk);
    @(negedge clk); chk("A_midclr_strobe", 64'(ia.bcd_valid), 64'd1);

    // asynchronous reset while in ADV
    push(0, 1, 1'b0);
    ia.run = 1'b1;
    wait_empty(0, 50, "A_pre_rst_timeout");
    @(posedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk("A_arst_value", 64'(ia.value), 64'd0);
    chk("A_arst_bcd", 64'(ia.bcd), 64'd0);
    chk("A_arst_valid", 64'(ia.bcd_valid), 64'd0);
    chk("A_arst_overflow", 64'(ia.overflow), 64'd0);
    chk("A_arst_busy", 64'(ia.busy), 64'd1);
    push(0, 0, 1'b0);
    ia.run = 1'b0;
    @(negedge clk); rst_a = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); chk("A_arst_release_early", 64'(ia.bcd_valid), 64'd0);
    @(posedge clk);
    @(negedge clk); chk("A_arst_release_strobe", 64'(ia.bcd_valid), 64'd1);

    // Lucas stepping: ADV on next edge, strobe 9 edges after that
    wait_empty(2, 10, "C_seed_timeout");
    push(2, 1, 1'b0);
    @(negedge clk); ic.step = 1'b1;
    @(negedge clk); ic.step = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); chk("C_step_early", 64'(ic.bcd_valid), 64'd0);
    @(posedge clk);
    @(negedge clk); chk("C_step_strobe", 64'(ic.bcd_valid), 64'd1);
    push(2, 3, 1'b0);
    push(2, 4, 1'b0);
    @(negedge clk); ic.step = 1'b1;
    @(negedge clk); ic.step = 1'b0;
    repeat (3) @(negedge clk);
    ic.step = 1'b1;
    @(negedge clk); ic.step = 1'b0;
    repeat (2) @(negedge clk);
    ic.step = 1'b1;
    @(negedge clk); ic.step = 1'b0;
    wait_empty(2, 60, "C_steps_timeout");
    repeat (30) @(negedge clk);
    chk("C_final_value", 64'(ic.value), 64'd4);
    chk("C_final_busy", 64'(ic.busy), 64'd0);

    wait_empty(1, 3000, "B_count_timeout");
    ib.run = 1'b0;
    strict[1] = 1'b0;
    chk("B_wrap_overflow", 64'(ib.overflow), 64'd1);

    wait_empty(3, 100, "D_fib_timeout");
    chk("D_final_overflow", 64'(id.overflow), 64'd1);
    chk("D_final_value", 64'(id.value), 64'd46368);
    chk("D_final_bcd", 64'(id.bcd), 64'h46368);
    chk("D_final_busy", 64'(id.busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
